// File: rtl/rv32_pipe_pkg.sv
// Shared constants and types for the RV32I pipeline boundary registers.
// NOP is the bubble value; count_t holds a 0..2 entry occupancy.
package rv32_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef logic [1:0] count_t;

  function automatic count_t occupancy(input logic a, input logic b);
    return count_t'(a) + count_t'(b);
  endfunction
endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: WIDTH-bit payload plus valid bit, async clear to RESET_VAL.
// Priority is clear > load > drop; drop empties the entry but keeps its stale data.
module pipe_entry_reg
  import rv32_pipe_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage boundary with a 2-entry skid buffer (main M drives outputs, skid S
// absorbs one beat under back-pressure), synchronous flush and a bubble value when empty.
module pipe_skid_reg
  import rv32_pipe_pkg::*;
#(
  parameter int             WIDTH        = 32,
  parameter logic [XLEN-1:0] RESET_VAL   = NOP,
  parameter bit             CLEAR_ON_POP = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output count_t           o_count
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  // Handshake: a beat moves on a side only at a rising edge where valid and ready
  // are both high; o_ready/o_valid come straight from registers and never depend
  // on i_valid/i_ready, and o_data holds while o_valid=1 and i_ready=0.
  logic             push;
  logic             pop;
  logic             m_free;

  logic             m_valid, s_valid;
  logic [WIDTH-1:0] m_data, s_data;

  logic             m_load, m_empty;
  logic [WIDTH-1:0] m_d;
  logic             s_load, s_empty;

  assign push   = i_valid & o_ready;
  assign pop    = m_valid & i_ready;
  assign m_free = ~m_valid | pop;

  always_comb begin
    m_load  = 1'b0;
    m_empty = 1'b0;
    m_d     = i_data;
    s_load  = 1'b0;
    s_empty = 1'b0;
    if (m_free) begin
      if (s_valid) begin
        m_load = 1'b1;
        m_d    = s_data;
        if (push) s_load  = 1'b1;
        else      s_empty = 1'b1;
      end else if (push) begin
        m_load = 1'b1;
      end else if (m_valid) begin
        m_empty = 1'b1;
      end
    end else if (push) begin
      s_load = 1'b1;
    end
  end

  pipe_entry_reg #(.WIDTH(WIDTH), .RESET_VAL(RST_V)) u_main (
    .clk   (i_clk),
    .rst_n (i_clr_n),
    .clear (i_flush | (m_empty & CLEAR_ON_POP)),
    .load  (m_load),
    .drop  (m_empty & ~CLEAR_ON_POP),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_data)
  );

  pipe_entry_reg #(.WIDTH(WIDTH), .RESET_VAL(RST_V)) u_skid (
    .clk   (i_clk),
    .rst_n (i_clr_n),
    .clear (i_flush | (s_empty & CLEAR_ON_POP)),
    .load  (s_load),
    .drop  (s_empty & ~CLEAR_ON_POP),
    .d     (i_data),
    .valid (s_valid),
    .q     (s_data)
  );

  assign o_valid = m_valid;
  assign o_data  = m_data;
  assign o_ready = ~s_valid;
  assign o_count = occupancy(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a CLEAR_ON_POP=1 and a CLEAR_ON_POP=0 instance share inputs;
// a reference FIFO queue is fed on accepted pushes and drained by a monitor on pops.
module tb_pipe_skid_reg;
  import rv32_pipe_pkg::*;

  logic        i_clk;
  logic        i_clr_n;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_ready;
  logic        o_ready,  o_valid;
  logic [31:0] o_data;
  count_t      o_count;
  logic        o_ready2, o_valid2;
  logic [31:0] o_data2;
  count_t      o_count2;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          done   = 0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(NOP), .CLEAR_ON_POP(1'b1)) u_dut (
    .i_clk(i_clk), .i_clr_n(i_clr_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_count(o_count)
  );

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(NOP), .CLEAR_ON_POP(1'b0)) u_dut2 (
    .i_clk(i_clk), .i_clr_n(i_clr_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready2), .i_data(i_data), .o_valid(o_valid2), .i_ready(i_ready),
    .o_data(o_data2), .o_count(o_count2)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change 1 time unit after the falling edge
  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(negedge i_clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
  endtask

  task automatic look(input string name, input logic v, input logic [31:0] d,
                      input int c, input logic rdy);
    #2;
    chk({name, "_valid"}, 32'(o_valid), 32'(v));
    chk({name, "_data"},  o_data, d);
    chk({name, "_count"}, 32'(o_count), 32'(c));
    chk({name, "_ready"}, 32'(o_ready), 32'(rdy));
  endtask

  // scoreboard feed: record accepted pushes, discard everything on flush
  initial forever begin
    @(negedge i_clk);
    #3;
    if (!done && i_clr_n) begin
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(i_data);
    end
  end

  // monitor: occupancy against the reference queue, pop data against its head
  initial forever begin
    int n;
    logic [31:0] e;
    @(negedge i_clk);
    #2;
    if (!done && i_clr_n) begin
      n = exp_q.size();
      chk("mon_count",  32'(o_count),  n);
      chk("mon_count2", 32'(o_count2), n);
      chk("mon_valid",  32'(o_valid),  32'(n != 0));
      chk("mon_valid2", 32'(o_valid2), 32'(n != 0));
      chk("mon_ready",  32'(o_ready),  32'(n < 2));
      chk("mon_ready2", 32'(o_ready2), 32'(n < 2));
      if (n == 0) chk("mon_bubble", o_data, NOP);
      if (o_valid && i_ready) begin
        if (n == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_pop_empty actual=pop required=no_pop t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pop_data",  o_data,  e);
          chk("mon_pop_data2", o_data2, e);
        end
      end
    end
  end

  initial begin
    i_clr_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    look("rst", 1'b0, NOP, 0, 1'b1);
    @(negedge i_clk);
    #1 i_clr_n = 1'b1;
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("idle", 1'b0, NOP, 0, 1'b1);

    // streaming at full rate
    cyc(1'b1, 32'h100, 1'b1, 1'b0);
    cyc(1'b1, 32'h104, 1'b1, 1'b0);
    look("st0", 1'b1, 32'h100, 1, 1'b1);
    cyc(1'b1, 32'h108, 1'b1, 1'b0);
    look("st1", 1'b1, 32'h104, 1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("st2", 1'b1, 32'h108, 1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("st3", 1'b0, NOP, 0, 1'b1);

    // back-pressure fills the skid entry, then drains in order
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    look("bp0", 1'b1, 32'hA, 1, 1'b1);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    look("bp1", 1'b1, 32'hA, 2, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    look("bp2", 1'b1, 32'hA, 2, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    look("bp3", 1'b1, 32'hA, 2, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    look("bp4", 1'b1, 32'hB, 1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("bp5", 1'b1, 32'hC, 1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("bp6", 1'b0, NOP, 0, 1'b1);

    // flush while full with a blocked 0xDEAD upstream
    cyc(1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    look("fl0", 1'b1, 32'h1, 2, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("fl1", 1'b0, NOP, 0, 1'b1);
    chk("fl1_data2", o_data2, NOP);

    // flush at count 1 with a pop and a push in the same cycle
    cyc(1'b1, 32'h21, 1'b1, 1'b0);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b1);
    look("fl2pre", 1'b1, 32'h21, 1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("fl2", 1'b0, NOP, 0, 1'b1);

    // asynchronous reset mid-cycle while full
    cyc(1'b1, 32'h31, 1'b0, 1'b0);
    cyc(1'b1, 32'h32, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    look("ar0", 1'b1, 32'h31, 2, 1'b0);
    @(negedge i_clk);
    #1;
    i_clr_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hBAD;
    exp_q.delete();
    #1;
    look("ar1", 1'b0, NOP, 0, 1'b1);
    @(negedge i_clk);
    #1;
    i_clr_n = 1'b1;
    i_valid = 1'b0;
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("ar2", 1'b1, 32'h55, 1, 1'b1);

    // stale data survives a pop only when CLEAR_ON_POP=0
    cyc(1'b1, 32'h77, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("cop0", 1'b0, NOP, 0, 1'b1);
    chk("cop0_data2", o_data2, 32'h77);
    chk("cop0_valid2", 32'(o_valid2), 32'h0);

    // random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 49) == 0));
    end
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    look("end", 1'b0, NOP, 0, 1'b1);

    done = 1'b1;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
